// File: rtl/inv_pipe.sv
// inv_pipe: bubble-collapsing valid/ready pipeline that transforms each accepted word once,
// on entry to stage 0, then carries it unchanged through DEPTH register stages.
//
// Transform, selected by mode and sampled with the accepted word:
//   00: in_data
//   01: ~in_data
//   10: in_data ^ mask
//   11: ~(in_data ^ mask)
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous, active-low reset
//   in_valid    upstream presents a word
//   in_ready    block accepts a word this cycle (combinational)
//   in_data     input word, WIDTH bits
//   mode        transform select, sampled with the accepted word
//   mask        bit mask, sampled with the accepted word
//   out_valid   out_data holds a valid word
//   out_ready   downstream accepts a word
//   out_data    transformed word from the last stage
//   out_parity  XOR-reduction of out_data (only with INV_PIPE_PARITY_EN defined)
//   occupancy   number of valid stages, 0..DEPTH
//
// Configuration macro: INV_PIPE_PARITY_EN adds a per-stage parity bit and the out_parity port.

module inv_pipe #(
    parameter int WIDTH = 52,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [1:0]                 mode,
    input  logic [WIDTH-1:0]           mask,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
`ifdef INV_PIPE_PARITY_EN
    output logic                       out_parity,
`endif
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] load;
    logic [WIDTH-1:0] xform;
    logic             accept;
    logic [OCC_W-1:0] occ_sum;

`ifdef INV_PIPE_PARITY_EN
    logic [DEPTH-1:0] par_q;
`endif

    // A stage loads when it is empty or when it advances. Unrolling the
    // recursion, stage k loads exactly when out_ready is high or any stage
    // from k to the end is empty; writing it this way keeps the chain free
    // of combinational self-reference.
    always_comb begin
        load = '0;
        for (int k = 0; k < DEPTH; k++) begin
            logic acc;
            acc = out_ready;
            for (int j = k; j < DEPTH; j++) begin
                acc = acc | ~valid_q[j];
            end
            load[k] = acc;
        end
    end

    always_comb begin
        xform = in_data;
        case (mode)
            2'b00:   xform = in_data;
            2'b01:   xform = ~in_data;
            2'b10:   xform = in_data ^ mask;
            default: xform = ~(in_data ^ mask);
        endcase
    end

    assign in_ready = load[0];
    assign accept   = in_valid & load[0];

    // Data registers only load when a valid word arrives, so empty stages
    // keep their last contents rather than toggling on every bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            if (load[0]) begin
                valid_q[0] <= in_valid;
            end
            if (accept) begin
                data_q[0] <= xform;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (load[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    if (valid_q[k-1]) begin
                        data_q[k] <= data_q[k-1];
                    end
                end
            end
        end
    end

`ifdef INV_PIPE_PARITY_EN
    // Parity is computed once from the transformed word and travels with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            par_q <= '0;
        end else begin
            if (accept) begin
                par_q[0] <= ^xform;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (load[k] && valid_q[k-1]) begin
                    par_q[k] <= par_q[k-1];
                end
            end
        end
    end

    assign out_parity = par_q[DEPTH-1];
`endif

    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_sum = occ_sum + OCC_W'(valid_q[i]);
        end
    end

    assign occupancy = occ_sum;
    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: tb/tb_inv_pipe.sv
// tb_inv_pipe: directed self-checking bench for inv_pipe (WIDTH=8, DEPTH=2).
// Inputs are driven and outputs sampled on the falling clock edge, away
// from the rising edge where the DUT updates.

module tb_inv_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       mode;
    logic [WIDTH-1:0] mask;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
`ifdef INV_PIPE_PARITY_EN
    logic             out_parity;
`endif

    int errors = 0;
    int checks = 0;

    inv_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mode      (mode),
        .mask      (mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef INV_PIPE_PARITY_EN
        .out_parity(out_parity),
`endif
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; in_data = 8'hFF; mode = 2'b01; mask = 8'h00; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_out_data got=%h exp=00", out_data); end
        checks++;
        if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL reset_occupancy got=%0d exp=0", occupancy); end
`ifdef INV_PIPE_PARITY_EN
        checks++;
        if (out_parity !== 1'b0) begin errors++; $display("[TB] FAIL reset_parity got=%b exp=0", out_parity); end
`endif
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL post_reset_occupancy got=%0d exp=0", occupancy); end
    endtask

    task automatic test_transform();
        logic [7:0] exp_data [4];
        exp_data[0] = 8'hA5; exp_data[1] = 8'h5A; exp_data[2] = 8'hAA; exp_data[3] = 8'h55;
        out_ready = 1'b1; mask = 8'h0F; in_data = 8'hA5;
        // Word i is accepted at the edge after falling edge i and is visible
        // from falling edge i+2 onward.
        for (int j = 0; j < 7; j++) begin
            if (j >= 2 && j < 6) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_data[j-2]) begin
                    errors++;
                    $display("[TB] FAIL transform_word%0d got valid=%b data=%h exp valid=1 data=%h", j-2, out_valid, out_data, exp_data[j-2]);
                end
            end else begin
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL transform_idle%0d got valid=%b exp=0", j, out_valid); end
            end
            if (j < 4) begin
                in_valid = 1'b1; mode = 2'(j);
            end else begin
                in_valid = 1'b0; mode = 2'b00;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; mode = 2'b00; in_valid = 1'b1; in_data = 8'h01;
        @(negedge clk);
        in_data = 8'h02; #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_half got=%b exp=1", in_ready); end
        @(negedge clk);
        in_data = 8'h03; #1;
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_full got occ=%0d ready=%b exp occ=2 ready=0", occupancy, in_ready);
        end
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h01 || occupancy !== 2'd2) begin
                errors++; $display("[TB] FAIL bp_stall%0d got valid=%b data=%h occ=%0d exp valid=1 data=01 occ=2", s, out_valid, out_data, occupancy);
            end
        end
        out_ready = 1'b1; #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_data !== 8'h02 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_drain1 got valid=%b data=%h exp data=02", out_valid, out_data); end
        @(negedge clk);
        checks++;
        if (out_data !== 8'h03 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_drain2 got valid=%b data=%h exp data=03", out_valid, out_data); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("[TB] FAIL bp_empty got valid=%b occ=%0d exp valid=0 occ=0", out_valid, occupancy); end
    endtask

    task automatic test_full_pass();
        out_ready = 1'b0; mode = 2'b00; in_valid = 1'b1; in_data = 8'h10;
        @(negedge clk);
        in_data = 8'h11;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'h12 + 8'(i); #1;
            checks++;
            if (in_ready !== 1'b1 || occupancy !== 2'd2 || out_valid !== 1'b1 || out_data !== 8'h10 + 8'(i)) begin
                errors++;
                $display("[TB] FAIL full_pass%0d got ready=%b occ=%0d valid=%b data=%h exp ready=1 occ=2 valid=1 data=%h",
                         i, in_ready, occupancy, out_valid, out_data, 8'h10 + 8'(i));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (out_data !== 8'h14) begin errors++; $display("[TB] FAIL full_tail1 got=%h exp=14", out_data); end
        @(negedge clk);
        checks++;
        if (out_data !== 8'h15 || occupancy !== 2'd1) begin errors++; $display("[TB] FAIL full_tail2 got data=%h occ=%0d exp data=15 occ=1", out_data, occupancy); end
        @(negedge clk);
        checks++;
        if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL full_empty got occ=%0d exp=0", occupancy); end
    endtask

    task automatic test_midflight_reset();
        out_ready = 1'b0; mode = 2'b00; in_valid = 1'b1; in_data = 8'h77;
        @(negedge clk);
        in_data = 8'h88;
        @(negedge clk);
        checks++;
        if (occupancy !== 2'd2) begin errors++; $display("[TB] FAIL mid_fill got occ=%0d exp=2", occupancy); end
        rst = 1'b0; in_data = 8'h99; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
            errors++; $display("[TB] FAIL mid_reset got occ=%0d valid=%b data=%h exp occ=0 valid=0 data=00", occupancy, out_valid, out_data);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_ghost%0d got valid=%b data=%h exp valid=0", i, out_valid, out_data); end
        end
    endtask

`ifdef INV_PIPE_PARITY_EN
    task automatic test_parity();
        out_ready = 1'b1; mode = 2'b00; in_valid = 1'b1; in_data = 8'h07;
        @(negedge clk);
        in_data = 8'h03;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h07 || out_parity !== 1'b1) begin
            errors++; $display("[TB] FAIL parity_07 got valid=%b data=%h par=%b exp data=07 par=1", out_valid, out_data, out_parity);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h03 || out_parity !== 1'b0) begin
            errors++; $display("[TB] FAIL parity_03 got valid=%b data=%h par=%b exp data=03 par=0", out_valid, out_data, out_parity);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; mode = 2'b00; mask = '0; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_transform();
        test_backpressure();
        test_full_pass();
        test_midflight_reset();
`ifdef INV_PIPE_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inv_pipe.md
INV_PIPE -- requirements
Module: inv_pipe

Interface
REQ-001 Parameter WIDTH, default 52: data lane width in bits; legal range 1 or more.
REQ-002 Parameter DEPTH, default 2: number of register stages; legal range 1 or more.
REQ-003 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-low.
REQ-005 Port in_valid, input, 1: upstream presents a word.
REQ-006 Port in_ready, output, 1: block accepts a word this cycle.
REQ-007 Port in_data, input, WIDTH: input word.
REQ-008 Port mode, input, 2: transform select, sampled with the accepted word.
REQ-009 Port mask, input, WIDTH: bit mask, sampled with the accepted word.
REQ-010 Port out_valid, output, 1: out_data holds a valid word.
REQ-011 Port out_ready, input, 1: downstream accepts a word.
REQ-012 Port out_data, output, WIDTH: transformed word from the last stage.
REQ-013 Port occupancy, output, $clog2(DEPTH+1): count of valid stages.
REQ-014 Port out_parity, output, 1: present only when INV_PIPE_PARITY_EN is defined.

Function
REQ-015 Transfer in and transfer out SHALL each occur on the edge where the respective valid and ready signals are both high.
REQ-016 The transform SHALL be applied once, on entry to stage 0, as follows:
- mode 00: in_data
- mode 01: ~in_data
- mode 10: in_data ^ mask
- mode 11: ~(in_data ^ mask)
REQ-017 mode and mask changes SHALL affect only words accepted after the change, never words already in flight.
REQ-018 Each stage SHALL hold a valid bit and a WIDTH data register; stage k loads from stage k-1, and stage DEPTH-1 drives out_data and out_valid.
REQ-019 Stage k SHALL load when it is empty, or when it is valid and itself advancing (downstream stage loading, or out_ready for the last stage); the pipeline is bubble-collapsing.
REQ-020 in_ready SHALL be combinational: high when stage 0 is empty or stage 0 advances this cycle.
REQ-021 With out_ready held high, a word accepted at edge N SHALL appear with out_valid high after edge N+DEPTH-1, i.e. DEPTH cycles of latency.
REQ-022 Sustained throughput SHALL be one word per cycle with no bubbles when in_valid and out_ready are both held high.
REQ-023 While out_valid is high and out_ready is low, out_data (and out_parity) SHALL hold stable; no word is dropped or duplicated.
REQ-024 When full (occupancy equals DEPTH) and out_ready is low, in_ready SHALL be low.
REQ-025 When full and out_ready is high, in_ready SHALL be high, with simultaneous accept and emit.
REQ-026 occupancy SHALL change as follows:
- +1 on accept-only
- -1 on emit-only
- unchanged on simultaneous accept and emit, or on neither
- never exceeds DEPTH and never goes below 0
REQ-027 Words SHALL exit in strict acceptance order.
REQ-028 Data registers of invalid stages SHALL hold their last value; out_data is don't-care when out_valid is low, except after reset.

Reset
REQ-029 While rst is low at a clock edge, all valid bits, all data registers and the parity bits SHALL clear to 0.
REQ-030 Reset values SHALL be: out_valid 0, out_data 0, occupancy 0, out_parity 0; in_ready reads 1 the cycle after rst is released.
REQ-031 A reset asserted mid-operation SHALL discard all in-flight words with no partial output, and no transfer occurs on that edge.

Configuration
REQ-032 Macro INV_PIPE_PARITY_EN defined: each stage SHALL carry one extra bit equal to the XOR-reduction of the transformed word computed at stage 0, presented on out_parity aligned with out_data.
REQ-033 Macro INV_PIPE_PARITY_EN undefined: the out_parity port and all parity registers SHALL be absent; all other behaviour is identical.

Verification (WIDTH=8, DEPTH=2 unless noted)
REQ-034 Reset check: hold rst low 2 cycles with in_valid=1 -> out_valid=0, out_data=0x00, occupancy=0; in_ready=1 after release.
REQ-035 Transform and latency check: accept 0xA5 with modes 00, 01, 10 and 11 (mask=0x0F) on consecutive cycles, out_ready=1 -> outputs 0xA5, 0x5A, 0xAA, 0x55 in that order, the first two cycles after its accept edge.
REQ-036 Backpressure check: out_ready=0, in_valid=1 with 0x01, 0x02, 0x03 -> occupancy 2, in_ready=0, 0x03 held off; raise out_ready -> 0x01, 0x02, 0x03 emitted in order with out_data stable while stalled.
REQ-037 Full pass-through check: full pipeline, in_valid=1, out_ready=1 -> in_ready=1, occupancy stays 2, one word per cycle.
REQ-038 Mid-flight reset check: two words in flight, pulse rst low 1 cycle -> occupancy=0, neither word ever appears on out_data.
REQ-039 Parity check (INV_PIPE_PARITY_EN defined): accept 0x07 with mode 00 -> out_parity=1; accept 0x03 with mode 00 -> out_parity=0.
